// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the ahb_slave_mem slice.
// Holds the transfer-type and slave-state enums, the hsize/hresp encodings
// and the byte-lane strobe helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DATA,
    ERR1,
    ERR2
  } slv_state_t;

  // Byte lanes touched by a transfer of the given size at the given
  // low address bits; illegal sizes touch nothing.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                             input logic [1:0] addr);
    logic [3:0] strobe;
    strobe = 4'b0000;
    case (size)
      HSIZE_BYTE: strobe = 4'b0001 << addr;
      HSIZE_HALF: strobe = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strobe = 4'b1111;
      default:    strobe = 4'b0000;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master/decoder and one memory slave.
// The master modport drives the request side (including the muxed hready);
// the slave modport drives hreadyout, hresp and hrdata.
interface ahb_slave_mem_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [31:0]       hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

endinterface

// File: rtl/ahb_slave_mem_array.sv
// Word-organised storage for ahb_slave_mem: MEM_DEPTH x 32 bits with a
// per-byte write enable, synchronous write and combinational read.
// Contents are deliberately not reset.
module ahb_slave_mem_array #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH];

  // Commit only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite on-chip SRAM slave fed by one hsel line of the upstream decoder.
// The address phase is registered and the data phase completes the access;
// misaligned, oversized or out-of-range transfers get a two-cycle ERROR.
// Build option: define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states
// ahead of every legal data phase; without it all legal transfers are
// zero-wait and WAIT_CYCLES has no effect.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               hclk,
  input  logic               hreset,
  ahb_slave_mem_if.slave     bus
);

  localparam int WORD_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(4 * MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
`ifdef AHB_SLV_WAIT_EN
  localparam bit WAIT_ON = (WAIT_CYCLES > 0);
`else
  localparam bit WAIT_ON = 1'b0;
`endif

  slv_state_t         state_q, state_d;
  logic [3:0]         waitCnt_q, waitCnt_d;
  logic [WORD_AW-1:0] wordAddr_q, wordAddr_d;
  logic [1:0]         lane_q, lane_d;
  logic               write_q, write_d;
  logic [2:0]         size_q, size_d;
  logic [31:0]        hrdata_q;

  logic        captureReq;
  logic        captureOpen;
  logic        capture;
  logic        sizeOk;
  logic        alignOk;
  logic        rangeOk;
  logic        legal;
  logic        readyOut;
  logic        respOut;
  logic [3:0]  memWe;
  logic [31:0] memRdata;
  logic [31:0] hrdataOut;
  logic        unusedBits;

  // hburst is ignored and htrans[0] only separates IDLE/BUSY or NONSEQ/SEQ,
  // neither of which changes how a beat is decoded here.
  assign unusedBits = ^{bus.hburst, bus.htrans[0]};

  assign captureReq  = bus.hsel & bus.hready & bus.htrans[1];
  assign captureOpen = (state_q == IDLE) || (state_q == DATA) || (state_q == ERR2);
  assign capture     = captureReq & captureOpen;

  // Legality of the transfer currently presented in its address phase.
  always_comb begin
    sizeOk  = (bus.hsize <= HSIZE_WORD);
    alignOk = 1'b1;
    case (bus.hsize)
      HSIZE_HALF: alignOk = ~bus.haddr[0];
      HSIZE_WORD: alignOk = (bus.haddr[1:0] == 2'b00);
      default:    alignOk = 1'b1;
    endcase
    rangeOk = ({1'b0, bus.haddr} < BYTE_LIMIT);
    legal   = sizeOk & alignOk & rangeOk;
  end

  // Next-state, address-phase capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    wordAddr_d = wordAddr_q;
    lane_d     = lane_q;
    write_d    = write_q;
    size_d     = size_q;
    readyOut   = 1'b1;
    respOut    = HRESP_OKAY;

    case (state_q)
      IDLE, DATA, ERR2: begin
        if (state_q == ERR2) begin
          respOut = HRESP_ERROR;
        end
        if (capture) begin
          wordAddr_d = bus.haddr[WORD_AW+1:2];
          lane_d     = bus.haddr[1:0];
          write_d    = bus.hwrite;
          size_d     = bus.hsize;
          if (!legal) begin
            state_d = ERR1;
          end else if (WAIT_ON) begin
            state_d   = WAIT;
            waitCnt_d = WAIT_LOAD;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        readyOut = 1'b0;
        if (waitCnt_q <= 4'd1) begin
          state_d = DATA;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      ERR1: begin
        readyOut = 1'b0;
        respOut  = HRESP_ERROR;
        state_d  = ERR2;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered address-phase controls.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      wordAddr_q <= '0;
      lane_q     <= 2'b00;
      write_q    <= 1'b0;
      size_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      wordAddr_q <= wordAddr_d;
      lane_q     <= lane_d;
      write_q    <= write_d;
      size_q     <= size_d;
    end
  end

  assign memWe = ((state_q == DATA) && write_q) ? byte_strobe(size_q, lane_q) : 4'b0000;

  ahb_slave_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (WORD_AW)
  ) u_array (
    .clk_i   (hclk),
    .we_i    (memWe),
    .addr_i  (wordAddr_q),
    .wdata_i (bus.hwdata),
    .rdata_o (memRdata)
  );

  assign hrdataOut = ((state_q == DATA) && !write_q) ? memRdata : hrdata_q;

  // Remember the last read word so hrdata holds outside read data phases.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hrdata_q <= 32'h0;
    end else begin
      hrdata_q <= hrdataOut;
    end
  end

  assign bus.hreadyout = readyOut;
  assign bus.hresp     = respOut;
  assign bus.hrdata    = hrdataOut;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed self-checking bench for ahb_slave_mem as a single slave whose
// hreadyout is fed straight back as hready. Works in both builds: the
// expected stall count per legal transfer follows AHB_SLV_WAIT_EN.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic hclk = 1'b0;
  logic hreset;
  int   checks   = 0;
  int   failures = 0;

  ahb_slave_mem_if #(.ADDR_W(32)) bus ();

  assign bus.hready = bus.hreadyout;

  ahb_slave_mem #(
    .ADDR_W      (32),
    .MEM_DEPTH   (256),
    .WAIT_CYCLES (2)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  // Free-running bus clock, 10 time units per cycle.
  always #5 hclk = ~hclk;

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one address phase (plus hwdata for the current data phase) and
  // step to just after the next rising edge.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                               input logic wr, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.hsel   = sel;
    bus.htrans = trans;
    bus.hwrite = wr;
    bus.hsize  = size;
    bus.haddr  = addr;
    bus.hburst = 3'b000;
    bus.hwdata = wdata;
    @(posedge hclk);
    #1;
  endtask

  task automatic idleCycle(input logic [31:0] wdata);
    applyStimulus(1'b1, TRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wdata);
  endtask

  // Step through wait states until the data phase is ready, bounded.
  task automatic waitReady(input string tag);
    int stalls;
    stalls = 0;
    while (bus.hreadyout !== 1'b1 && stalls < 32) begin
      @(posedge hclk);
      #1;
      stalls++;
    end
    checkOutput(tag, 32'(stalls), 32'(EXP_WAITS));
  endtask

  initial begin
    hreset     = 1'b1;
    bus.hsel   = 1'b0;
    bus.htrans = TRANS_IDLE;
    bus.hwrite = 1'b0;
    bus.hsize  = HSIZE_WORD;
    bus.haddr  = 32'h0;
    bus.hburst = 3'b000;
    bus.hwdata = 32'h0;
    #1;
    checkOutput("rst_ready", 32'(bus.hreadyout), 32'h1);
    checkOutput("rst_resp", 32'(bus.hresp), 32'h0);
    checkOutput("rst_rdata", bus.hrdata, 32'h0);
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    @(posedge hclk);
    #1;

    // Word write then pipelined word read of the same address.
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h04, 32'h0);
    waitReady("wr04_waits");
    checkOutput("wr04_resp", 32'(bus.hresp), 32'h0);
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04, 32'hDEADBEEF);
    waitReady("rd04_waits");
    checkOutput("rd04_data", bus.hrdata, 32'hDEADBEEF);
    checkOutput("rd04_resp", 32'(bus.hresp), 32'h0);
    idleCycle(32'h0);
    checkOutput("rd04_hold", bus.hrdata, 32'hDEADBEEF);

    // Byte and halfword lanes merged into a cleared word.
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
    waitReady("wr20_waits");
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h21, 32'h00000000);
    waitReady("wr21_waits");
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h22, 32'h0000AA00);
    waitReady("wr22_waits");
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h12340000);
    waitReady("rd20_waits");
    checkOutput("rd20_data", bus.hrdata, 32'h1234AA00);
    idleCycle(32'h0);

    // Misaligned word write: two-cycle ERROR, word 0 untouched.
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h00, 32'h0);
    waitReady("wr00_waits");
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h02, 32'hCAFEF00D);
    checkOutput("mis_err1_ready", 32'(bus.hreadyout), 32'h0);
    checkOutput("mis_err1_resp", 32'(bus.hresp), 32'h1);
    idleCycle(32'hFFFFFFFF);
    checkOutput("mis_err2_ready", 32'(bus.hreadyout), 32'h1);
    checkOutput("mis_err2_resp", 32'(bus.hresp), 32'h1);
    idleCycle(32'hFFFFFFFF);
    checkOutput("mis_after_resp", 32'(bus.hresp), 32'h0);
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'hFFFFFFFF);
    waitReady("rd00_waits");
    checkOutput("mis_mem_kept", bus.hrdata, 32'hCAFEF00D);

    // Out-of-range word write at 0x400 pipelined behind the read.
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h400, 32'h0);
    checkOutput("oor_err1_ready", 32'(bus.hreadyout), 32'h0);
    checkOutput("oor_err1_resp", 32'(bus.hresp), 32'h1);
    idleCycle(32'h77777777);
    checkOutput("oor_err2_ready", 32'(bus.hreadyout), 32'h1);
    checkOutput("oor_err2_resp", 32'(bus.hresp), 32'h1);
    idleCycle(32'h77777777);

    // No capture for IDLE with hsel=1 or NONSEQ with hsel=0.
    applyStimulus(1'b1, TRANS_IDLE, 1'b1, HSIZE_WORD, 32'h00, 32'h0);
    checkOutput("idle_ready", 32'(bus.hreadyout), 32'h1);
    checkOutput("idle_resp", 32'(bus.hresp), 32'h0);
    idleCycle(32'h55555555);
    applyStimulus(1'b0, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h00, 32'h0);
    checkOutput("nosel_ready", 32'(bus.hreadyout), 32'h1);
    checkOutput("nosel_resp", 32'(bus.hresp), 32'h0);
    idleCycle(32'h66666666);
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'h0);
    waitReady("rd00b_waits");
    checkOutput("nowrite_mem_kept", bus.hrdata, 32'hCAFEF00D);

    // Word read at 0x08 (wait states when the feature is built in).
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h08, 32'h0);
    waitReady("wr08_waits");
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h08, 32'h0BADC0DE);
    waitReady("rd08_waits");
    checkOutput("rd08_data", bus.hrdata, 32'h0BADC0DE);
    idleCycle(32'h0);

    // Reset asserted in the middle of a write data phase to 0x10.
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
    waitReady("wr10_waits");
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h11111111);
    waitReady("rd10_waits");
    checkOutput("rd10_data", bus.hrdata, 32'h11111111);
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
    waitReady("wr10b_waits");
    bus.htrans = TRANS_IDLE;
    bus.hwdata = 32'h99999999;
    #2;
    hreset = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(bus.hreadyout), 32'h1);
    checkOutput("midrst_resp", 32'(bus.hresp), 32'h0);
    checkOutput("midrst_rdata", bus.hrdata, 32'h0);
    @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    applyStimulus(1'b1, TRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    waitReady("rd10b_waits");
    checkOutput("midrst_mem_kept", bus.hrdata, 32'h11111111);
    idleCycle(32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
